pixel_span_writer: RTL and testbench

// - Nios II multi-cycle custom instruction that draws into the SRAM framebuffer through the shared addr/data/wr/busy write port.
// - Opcodes: set a colour register, write one pixel, or fill a horizontal/vertical span of up to 65535 pixels from one instruction.
// - Sits between the CPU custom-instruction slave and the framebuffer arbiter; replaces one-pixel-per-instruction drawing for lines and fills.

---
 rtl/pixel_span_writer.sv | 152 +++++++++++++++
 tb/tb_pixel_span_writer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_span_writer.sv
// pixel_span_writer: custom instruction drawing pixels and H/V spans into the framebuffer port.
// Build option PIXEL_CLIP_EN: skip off-screen pixels and stop spans at the screen edge.
module pixel_span_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              start,
    input  logic [1:0]        n,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic              done,
    output logic [31:0]       result,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              wr,
    input  logic              busy
);

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_PIX = 2'd1;
    localparam logic [1:0] OP_H   = 2'd2;
    localparam logic [1:0] OP_V   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        op;
    logic [15:0]       x;
    logic [15:0]       y;
    logic [15:0]       len;
    logic [15:0]       count;
    logic [DATA_W-1:0] colour;
    logic [DATA_W-1:0] pix;
    logic [ADDR_W-1:0] addr_acc;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] step;
    logic [15:0]       nx;
    logic [15:0]       ny;
    logic              pix_ok;
    logic              stop_now;
    logic              stop_next;

    function automatic logic on_screen(input logic [15:0] px, input logic [15:0] py);
        int xi;
        int yi;
        xi = int'($signed(px));
        yi = int'($signed(py));
        return (xi >= 0) && (xi < H_RES) && (yi >= 0) && (yi < V_RES);
    endfunction

    function automatic logic past_edge(input logic [15:0] p, input int lim);
        return int'($signed(p)) >= lim;
    endfunction

    assign nx   = x + 16'd1;
    assign ny   = y + 16'd1;
    assign base = ADDR_W'(int'($signed(y)) * H_RES + int'($signed(x)));
    assign step = (op == OP_V) ? ADDR_W'(H_RES) : ADDR_W'(1);

`ifdef PIXEL_CLIP_EN
    assign pix_ok    = on_screen(x, y);
    assign stop_now  = (op == OP_H && past_edge(x, H_RES)) ||
                       (op == OP_V && past_edge(y, V_RES));
    assign stop_next = (op == OP_H && past_edge(nx, H_RES)) ||
                       (op == OP_V && past_edge(ny, V_RES));
`else
    assign pix_ok    = 1'b1;
    assign stop_now  = 1'b0;
    assign stop_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op       <= OP_SET;
            x        <= '0;
            y        <= '0;
            len      <= '0;
            count    <= '0;
            colour   <= '0;
            pix      <= '0;
            addr_acc <= '0;
            done     <= 1'b0;
            result   <= '0;
            addr     <= '0;
            data     <= '0;
            wr       <= 1'b0;
        end else if (clk_en) begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= n;
                        x     <= dataa[15:0];
                        y     <= dataa[31:16];
                        count <= '0;
                        if (n == OP_SET) begin
                            colour <= datab[DATA_W-1:0];
                            state  <= S_DONE;
                        end else begin
                            len   <= (n == OP_PIX) ? 16'd1 : datab[15:0];
                            pix   <= (n == OP_PIX) ? datab[DATA_W-1:0] : colour;
                            state <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    addr_acc <= base;
                    state    <= (len == 16'd0 || stop_now) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    // off-screen pixels use up their step without waiting on busy
                    if (!pix_ok) begin
                        state <= S_WRITE;
                    end else if (!busy) begin
                        wr    <= 1'b1;
                        addr  <= addr_acc;
                        data  <= pix;
                        count <= count + 16'd1;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr       <= 1'b0;
                    addr_acc <= addr_acc + step;
                    len      <= len - 16'd1;
                    if (op == OP_V) y <= ny;
                    else            x <= nx;
                    state <= (len == 16'd1 || stop_next) ? S_DONE : S_WAIT;
                end
                S_DONE: begin
                    done   <= 1'b1;
                    result <= {16'd0, count};
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_span_writer.sv
// tb_pixel_span_writer: directed and random checks of pixel_span_writer
// against a span-level reference model of pixels, addresses and counts.
module tb_pixel_span_writer;

    localparam int AW = 19;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_en;
    logic          start;
    logic [1:0]    n;
    logic [31:0]   dataa;
    logic [31:0]   datab;
    logic          done;
    logic [31:0]   result;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          wr;
    logic          busy;

    int passed = 0;
    int total  = 0;

    logic [AW+DW-1:0] obs[$];
    logic [AW+DW-1:0] exp_q[$];
    int               exp_res;
    logic [31:0]      col_m = 32'd0;
    int               bmode = 0;
    int               hold  = 0;
    int               viol  = 0;
    logic             wr_prev = 1'b0;
    logic             busy_prev = 1'b0;

    pixel_span_writer dut (
        .clk    (clk),
        .reset_n(reset_n),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .dataa  (dataa),
        .datab  (datab),
        .done   (done),
        .result (result),
        .addr   (addr),
        .data   (data),
        .wr     (wr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // framebuffer side: a write lands on each enabled edge that sees wr
    always @(posedge clk) begin
        if (!reset_n) begin
            wr_prev = 1'b0;
        end else if (clk_en) begin
            if (wr) obs.push_back({addr, data});
            if (wr && !wr_prev && busy_prev) viol++;
            wr_prev   = wr;
            busy_prev = busy;
        end
    end

    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bmode)
                1: busy = 1'($urandom_range(0, 1));
                2: begin
                    if (hold < 5) begin
                        busy = 1'b1;
                        hold++;
                    end else begin
                        busy = 1'b0;
                        if (wr) hold = 0;
                    end
                end
                default: busy = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int wrap16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    // reference: enumerate the pixels an instruction touches
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int x0, y0, len, dx, dy;
        logic [31:0] c;
        logic [31:0] ad;
        exp_q.delete();
        exp_res = 0;
        if (op == 2'd0) begin
            col_m = b;
            return;
        end
        len = (op == 2'd1) ? 1 : int'(b[15:0]);
        c   = (op == 2'd1) ? b : col_m;
        x0  = int'($signed(a[15:0]));
        y0  = int'($signed(a[31:16]));
        for (int i = 0; i < len; i++) begin
            dx = (op == 2'd3) ? 0 : i;
            dy = (op == 2'd3) ? i : 0;
`ifdef PIXEL_CLIP_EN
            begin
                int px, py;
                px = wrap16(x0 + dx);
                py = wrap16(y0 + dy);
                if (op == 2'd2 && px >= 640) break;
                if (op == 2'd3 && py >= 480) break;
                if (px < 0 || px >= 640 || py < 0 || py >= 480) continue;
            end
`endif
            ad = 32'((y0 + dy) * 640 + x0 + dx);
            exp_q.push_back({ad[AW-1:0], c});
            exp_res++;
        end
    endtask

    function automatic int qdiff();
        int d = 0;
        if (obs.size() != exp_q.size()) return 1000 + obs.size();
        foreach (obs[i]) if (obs[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        model(op, a, b);
        obs.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        n     = op;
        dataa = a;
        datab = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        n       = 2'd0;
        dataa   = '0;
        datab   = '0;
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else passed++;
        total++;
        if (wr !== 1'b0) $display("FAIL reset_wr got %b want 0", wr);
        else passed++;
        total++;
        if (addr !== '0) $display("FAIL reset_addr got %0d want 0", addr);
        else passed++;
        total++;
        if (data !== '0) $display("FAIL reset_data got %h want 0", data);
        else passed++;
        total++;
        if (result !== '0) $display("FAIL reset_result got %0d want 0", result);
        else passed++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_pixel();
        bit got;
        issue(2'd1, 32'h0002_0003, 32'hAABB_CCDD);
        wait_done(50, got);
        total++;
        if (!got) $display("FAIL pixel_done got timeout want pulse");
        else passed++;
        total++;
        if (result !== 32'd1) $display("FAIL pixel_result got %0d want 1", result);
        else passed++;
        total++;
        if (obs.size() !== 1 || obs[0] !== {19'd1283, 32'hAABB_CCDD})
            $display("FAIL pixel_write got %0d writes want 1 at 1283/aabbccdd", obs.size());
        else passed++;
    endtask

    task automatic test_hspan();
        bit got;
        issue(2'd0, 32'd0, 32'h00FF_00FF);
        wait_done(20, got);
        total++;
        if (!got || result !== 32'd0 || obs.size() !== 0)
            $display("FAIL setcolor got done=%b res=%0d wr=%0d want 1/0/0",
                     got, result, obs.size());
        else passed++;
        issue(2'd2, 32'h0000_0000, 32'd4);
        wait_done(100, got);
        total++;
        if (!got || result !== 32'd4) $display("FAIL hspan_result got %0d want 4", result);
        else passed++;
        total++;
        if (qdiff() != 0) $display("FAIL hspan_writes got %0d diffs want 0", qdiff());
        else passed++;
        total++;
        if (obs.size() !== 4 || obs[3] !== {19'd3, 32'h00FF_00FF})
            $display("FAIL hspan_last got %0d writes want 4 ending 3/00ff00ff", obs.size());
        else passed++;
    endtask

    task automatic test_vspan_busy();
        bit got;
        viol  = 0;
        hold  = 0;
        bmode = 2;
        issue(2'd3, 32'h0001_000A, 32'd3);
        wait_done(200, got);
        bmode = 0;
        total++;
        if (!got || result !== 32'd3) $display("FAIL vspan_result got %0d want 3", result);
        else passed++;
        total++;
        if (obs.size() !== 3 || obs[0][50:32] !== 19'd650 ||
            obs[1][50:32] !== 19'd1290 || obs[2][50:32] !== 19'd1930)
            $display("FAIL vspan_addr got %0d writes want 650,1290,1930", obs.size());
        else passed++;
        total++;
        if (viol !== 0) $display("FAIL vspan_busy got %0d writes under busy want 0", viol);
        else passed++;
    endtask

    task automatic test_clip_edges();
        bit got;
        issue(2'd2, 32'h0000_027E, 32'd5);
        wait_done(100, got);
        total++;
`ifdef PIXEL_CLIP_EN
        if (!got || result !== 32'd2) $display("FAIL edge_right got %0d want 2", result);
`else
        if (!got || result !== 32'd5) $display("FAIL edge_right got %0d want 5", result);
`endif
        else passed++;
        total++;
        if (qdiff() != 0) $display("FAIL edge_right_writes got %0d diffs want 0", qdiff());
        else passed++;
        issue(2'd2, 32'h0000_FFFE, 32'd4);
        wait_done(100, got);
        total++;
`ifdef PIXEL_CLIP_EN
        if (!got || result !== 32'd2) $display("FAIL edge_left got %0d want 2", result);
`else
        if (!got || result !== 32'd4) $display("FAIL edge_left got %0d want 4", result);
`endif
        else passed++;
        total++;
        if (qdiff() != 0) $display("FAIL edge_left_writes got %0d diffs want 0", qdiff());
        else passed++;
    endtask

    task automatic test_len0();
        logic [2:0] d;
        issue(2'd2, 32'h0005_0005, 32'd0);
        @(negedge clk) d[2] = done;
        @(negedge clk) d[1] = done;
        @(negedge clk) d[0] = done;
        total++;
        if (d !== 3'b001) $display("FAIL len0_timing got %b want 001", d);
        else passed++;
        total++;
        if (result !== 32'd0 || obs.size() !== 0)
            $display("FAIL len0_result got %0d/%0d writes want 0/0", result, obs.size());
        else passed++;
    endtask

    task automatic test_clk_en();
        bit got;
        bit seen;
        int bad;
        logic [AW-1:0] fa;
        issue(2'd2, {16'd5, 16'd20}, 32'd10);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wr) begin
                seen = 1'b1;
                break;
            end
        end
        #1 clk_en = 1'b0;
        fa  = addr;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr !== 1'b1 || addr !== fa || done !== 1'b0) bad++;
        end
        total++;
        if (!seen || bad != 0) $display("FAIL freeze got seen=%b bad=%0d want 1/0", seen, bad);
        else passed++;
        @(posedge clk);
        #1 clk_en = 1'b1;
        wait_done(100, got);
        total++;
        if (!got || result !== 32'd10) $display("FAIL freeze_result got %0d want 10", result);
        else passed++;
        total++;
        if (qdiff() != 0) $display("FAIL freeze_writes got %0d diffs want 0", qdiff());
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit got;
        bit seen;
        int dp;
        issue(2'd2, {16'd10, 16'd0}, 32'd100);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wr && obs.size() >= 5) begin
                seen = 1'b1;
                break;
            end
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (!seen || wr !== 1'b0) $display("FAIL reset_mid_wr got seen=%b wr=%b want 1/0", seen, wr);
        else passed++;
        col_m = 32'd0;
        dp = 0;
        repeat (2) @(negedge clk) if (done) dp++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(negedge clk) if (done) dp++;
        total++;
        if (dp != 0) $display("FAIL reset_mid_done got %0d pulses want 0", dp);
        else passed++;
        issue(2'd2, {16'd1, 16'd1}, 32'd2);
        wait_done(100, got);
        total++;
        if (!got || result !== 32'd2 || qdiff() != 0)
            $display("FAIL reset_mid_next got %0d diffs=%0d want 2/0", result, qdiff());
        else passed++;
    endtask

    task automatic test_random();
        bit got;
        logic [1:0] op;
        logic [31:0] a, b;
        int xr, yr;
        viol  = 0;
        bmode = 1;
        for (int k = 0; k < 25; k++) begin
            op = 2'($urandom_range(0, 3));
            xr = int'($urandom_range(0, 720)) - 12;
            yr = int'($urandom_range(0, 500)) - 12;
            a  = {yr[15:0], xr[15:0]};
            b  = (op == 2'd2 || op == 2'd3) ? 32'($urandom_range(0, 24)) : $urandom;
            issue(op, a, b);
            wait_done(400, got);
            total++;
            if (!got || result !== 32'(exp_res))
                $display("FAIL rand%0d_result got %0d want %0d", k, result, exp_res);
            else passed++;
            total++;
            if (qdiff() != 0) $display("FAIL rand%0d_writes got %0d diffs want 0", k, qdiff());
            else passed++;
        end
        bmode = 0;
        total++;
        if (viol !== 0) $display("FAIL rand_busy got %0d writes under busy want 0", viol);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_hspan();
        test_vspan_busy();
        test_clip_edges();
        test_len0();
        test_clk_en();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
